// File: rtl/des_round_ctrl_if.sv
// Request / datapath-strobe / result bundle of the DES round sequencer.
// slave  : the controller side (des_round_ctrl)
// master : the requester / datapath / consumer side
interface des_round_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_e;
  logic [55:0]      in_kp;
  logic             dp_load;
  logic             dp_round;
  logic             dp_final;
  logic [55:0]      cd;
  logic [CNT_W-1:0] round;
  logic             busy;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_valid, in_e, in_kp, out_ready,
    output in_ready, dp_load, dp_round, dp_final, cd, round, busy, out_valid
  );

  modport master (
    output in_valid, in_e, in_kp, out_ready,
    input  in_ready, dp_load, dp_round, dp_final, cd, round, busy, out_valid
  );
endinterface

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: one round per clock.
// Owns the C/D key-schedule registers and strobes the external L/R datapath.
// Optional feature macro: DES_DECRYPT_EN (decrypt key schedule, in_e honoured).
// Without it the block is encrypt-only and in_e is ignored.
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 4
) (
  input logic             clk,
  input logic             rst_n,
  des_round_ctrl_if.slave bus
);

  // Bit i set means shift table entry i is 2, otherwise 1.
  // Table: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
  localparam logic [15:0]      SCHED2 = 16'h7EFC;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN, OUT} state_t;

  // Rotate C and D halves independently by 1 or 2.
  function automatic logic [55:0] rotl_step(input logic [55:0] x, input logic two);
    logic [27:0] c, d;
    c = x[55:28];
    d = x[27:0];
    if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
    return {c[26:0], c[27], d[26:0], d[27]};
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [55:0] rotr_step(input logic [55:0] x, input logic two);
    logic [27:0] c, d;
    c = x[55:28];
    d = x[27:0];
    if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
    return {c[0], c[27:1], d[0], d[27:1]};
  endfunction

  // Total rotation over all executed rounds, mod 28: the decrypt start key.
  function automatic int sched_sum();
    int s;
    s = 0;
    for (int i = 0; i < ROUNDS; i++) s += SCHED2[i] ? 2 : 1;
    return s % 28;
  endfunction

  localparam int DEC_S = sched_sum();
`endif

  state_t           state_q, state_d;
  logic [55:0]      cd_q, cd_acc, cd_step;
  logic [CNT_W-1:0] round_q, idx_enc;

`ifdef DES_DECRYPT_EN
  logic             e_q;
  logic [CNT_W-1:0] idx_dec;
  logic [55:0]      kp_dec;
`else
  logic             unused_in_e;
  assign unused_in_e = bus.in_e;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/strobe decode
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.dp_load   = 1'b0;
    bus.dp_round  = 1'b0;
    bus.dp_final  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.dp_load  = bus.in_valid;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        bus.dp_round = 1'b1;
        if (round_q == LAST) state_d = FIN;
      end
      FIN: begin
        bus.dp_final = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx_enc = round_q + CNT_W'(1);

`ifdef DES_DECRYPT_EN
  assign idx_dec = LAST - round_q;

  // Decrypt start key: input key rotated by the whole schedule
  always_comb begin
    kp_dec = bus.in_kp;
    for (int i = 0; i < DEC_S; i++) kp_dec = rotl_step(kp_dec, 1'b0);
  end
`endif

  // Key loaded on accept: first encrypt key or last-round key for decrypt
  always_comb begin
    cd_acc = rotl_step(bus.in_kp, SCHED2[0]);
`ifdef DES_DECRYPT_EN
    if (!bus.in_e) cd_acc = kp_dec;
`endif
  end

  // Per-round key advance: forward for encrypt, reverse walk for decrypt
  always_comb begin
    cd_step = rotl_step(cd_q, SCHED2[idx_enc]);
`ifdef DES_DECRYPT_EN
    if (!e_q) cd_step = rotr_step(cd_q, SCHED2[idx_dec]);
`endif
  end

  // Key schedule, round counter and direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q    <= '0;
      round_q <= '0;
`ifdef DES_DECRYPT_EN
      e_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          cd_q    <= cd_acc;
          round_q <= '0;
`ifdef DES_DECRYPT_EN
          e_q     <= bus.in_e;
`endif
        end
        RUN: if (round_q != LAST) begin
          cd_q    <= cd_step;
          round_q <= round_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.cd    = cd_q;
  assign bus.round = round_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl: a cycle-timeline model of the
// sequencer plus an arithmetic key-schedule model, compared every cycle,
// with directed key-schedule, reset, backpressure and throughput cases and
// a randomized soak (including a mid-run reset).
module tb_des_round_ctrl;
  localparam int R = 16;
  localparam logic [55:0] KP  = 56'hF0CCAAF556678F;
  localparam logic [55:0] K1  = 56'hE19955FAACCF1E;
`ifdef DES_DECRYPT_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_round_ctrl_if #(.CNT_W(4)) bus ();

  des_round_ctrl #(.ROUNDS(R), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int sched [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [27:0] rot28(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {28'b0, x} << n;
    return t[27:0] | t[55:28];
  endfunction

  // Round key source for round r: total left rotation = sum of shifts up to
  // that round; decrypt walks the encrypt keys backwards.
  function automatic logic [55:0] mkey(input logic [55:0] kp, input bit e, input int r);
    int n, idx;
    n   = 0;
    idx = e ? r : R - 1 - r;
    for (int i = 0; i <= idx; i++) n += sched[i];
    n = n % 28;
    return {rot28(kp[55:28], n), rot28(kp[27:0], n)};
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  // phase 0 = idle, 1..R = round phase-1, R+1 = final strobe, >R+1 = result held
  int          phase = 0;
  bit          m_e = 1'b1;
  logic [55:0] m_kp = '0;
  logic [55:0] last_cd = '0;
  int          last_rnd = 0;

  always @(negedge clk) begin
    logic [55:0] ecd;
    int          ernd;
    if (!rst_n) begin
      phase    = 0;
      last_cd  = '0;
      last_rnd = 0;
    end else begin
      if (phase == 0) begin
        ecd = last_cd; ernd = last_rnd;
      end else if (phase <= R) begin
        ecd = mkey(m_kp, m_e, phase - 1); ernd = phase - 1;
      end else begin
        ecd = mkey(m_kp, m_e, R - 1); ernd = R - 1;
      end
      chk("in_ready",  64'(bus.in_ready),  64'(phase == 0));
      chk("dp_load",   64'(bus.dp_load),   64'(phase == 0 && bus.in_valid));
      chk("dp_round",  64'(bus.dp_round),  64'(phase >= 1 && phase <= R));
      chk("dp_final",  64'(bus.dp_final),  64'(phase == R + 1));
      chk("out_valid", 64'(bus.out_valid), 64'(phase > R + 1));
      chk("busy",      64'(bus.busy),      64'(phase != 0));
      chk("cd",        64'(bus.cd),        64'(ecd));
      chk("round",     64'(bus.round),     64'(ernd));
      // advance to the state after the coming edge
      if (phase == 0) begin
        if (bus.in_valid) begin
          m_e   = DEC ? bus.in_e : 1'b1;
          m_kp  = bus.in_kp;
          phase = 1;
        end
      end else if (phase <= R + 1) begin
        phase++;
      end else if (bus.out_ready) begin
        phase    = 0;
        last_cd  = mkey(m_kp, m_e, R - 1);
        last_rnd = R - 1;
      end
    end
  end

  // Cycle stamps of dp_load and out_valid rising, for the throughput case
  bit rec = 1'b0;
  bit ov_prev = 1'b0;
  int q_load[$];
  int q_ov[$];
  always @(negedge clk) begin
    if (rec) begin
      if (bus.dp_load) q_load.push_back(cyc);
      if (bus.out_valid && !ov_prev) q_ov.push_back(cyc);
    end
    ov_prev = bus.out_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [55:0] kp, input bit e);
    bus.in_kp = kp; bus.in_e = e; bus.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_kp = ~kp; bus.in_e = ~e;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.busy) begin @(posedge clk); #1; return; end
    end
    chk("idle_timeout", 64'd0, 64'd1);
  endtask

  // Follow one accepted block: literal keys at first/last round, run length.
  task automatic watch(input logic [55:0] k0, input logic [55:0] k15);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.dp_round) begin
        n++;
        if (bus.round == 4'd0)  chk("cd_round0",  64'(bus.cd), 64'(k0));
        if (bus.round == 4'd15) chk("cd_round15", 64'(bus.cd), 64'(k15));
      end
      if (bus.dp_final) break;
    end
    chk("dp_round_len", 64'(n), 64'd16);
    wait_idle();
  endtask

  initial begin
    logic [63:0] r64;
    bus.in_valid = 1'b0; bus.in_e = 1'b1; bus.in_kp = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_cd", 64'(bus.cd), 64'd0);
    @(posedge clk); #1;

    // Pin the arithmetic key model with hand-computed keys
    chk("model_enc_r0",  64'(mkey(KP, 1'b1, 0)),  64'(K1));
    chk("model_enc_r15", 64'(mkey(KP, 1'b1, 15)), 64'(KP));
    chk("model_dec_r0",  64'(mkey(KP, 1'b0, 0)),  64'(KP));
    chk("model_dec_r15", 64'(mkey(KP, 1'b0, 15)), 64'(K1));

    // Encrypt key schedule
    send(KP, 1'b1);
    watch(K1, KP);

    // Decrypt (or, without the decrypt build, in_e ignored)
    send(KP, 1'b0);
    if (DEC) watch(KP, K1);
    else     watch(K1, KP);

    // Async reset in the middle of RUN
    send(KP, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.dp_round && bus.round == 4'd7) break;
    end
    chk("at_round7", 64'(bus.round), 64'd7);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_cd",    64'(bus.cd), 64'd0);
    chk("rst_round", 64'(bus.round), 64'd0);
    chk("rst_strobes", 64'({bus.dp_load, bus.dp_round, bus.dp_final, bus.out_valid}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Backpressure on the result
    bus.out_ready = 1'b0;
    send(56'h123456789ABCDE, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1 bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_no_accept",  64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_accept_load", 64'(bus.dp_load), 64'd1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_idle();

    // Throughput: in_valid and out_ready tied high for three blocks
    q_load.delete(); q_ov.delete();
    rec = 1'b1;
    bus.in_kp = KP; bus.in_e = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.dp_load && q_load.size() >= 2) begin
        @(posedge clk); #1 bus.in_valid = 1'b0;
        break;
      end
    end
    for (int k = 0; k < 100 && q_ov.size() < 3; k++) @(negedge clk);
    rec = 1'b0;
    chk("tp_loads", 64'(q_load.size()), 64'd3);
    chk("tp_outs",  64'(q_ov.size()), 64'd3);
    if (q_load.size() == 3 && q_ov.size() == 3) begin
      chk("tp_load1", 64'(q_load[1] - q_load[0]), 64'd19);
      chk("tp_load2", 64'(q_load[2] - q_load[0]), 64'd38);
      chk("tp_ov0",   64'(q_ov[0] - q_load[0]), 64'd18);
      chk("tp_ov1",   64'(q_ov[1] - q_load[0]), 64'd37);
      chk("tp_ov2",   64'(q_ov[2] - q_load[0]), 64'd56);
    end
    @(posedge clk); #1;
    wait_idle();

    // Randomized soak: random handshakes, inputs churning, one mid-run reset
    for (int k = 0; k < 1200; k++) begin
      r64 = {$urandom(), $urandom()};
      bus.in_kp     = r64[55:0];
      bus.in_e      = 1'($urandom_range(0, 1));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (k == 600) rst_n = 1'b0;
      if (k == 602) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
